hazard_ctrl_unit: RTL

- Parametrised successor to the single-cycle load-use hazard detector in the 5-stage RISC-V pipeline.
- Generates per-stage stall and flush controls for four hazard sources: load-use with a configurable bubble count, multi-cycle execute ops (mul/div), data-memory wait states, and taken branches/jumps resolved in E.
- Keeps a saturating stall-cycle counter for performance monitoring.
- Sits beside the forwarding unit; drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and clears.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_ctrl_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard controller states, stage control bundle
// and register-index constants.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int X0_IDX     = 0;
  localparam int HZ_CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE = '{default: 1'b0};

  // Clamp a bubble/latency preload into the controller counter width.
  function automatic logic [HZ_CNT_W-1:0] preload(input int total);
    int v;
    v = (total > 1) ? total - 2 : 0;
    return v[HZ_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
// One-cycle update, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = &r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Per-stage stall/flush generator for load-use, multi-cycle E, memory wait and taken branches.
// Outputs are combinational from state, counter and inputs; never waits on downstream.
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int LU_BUBBLES = 1,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadE,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              UseRs1_D,
  input  logic              UseRs2_D,
  input  logic              MultiCycE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [CNT_W-1:0]  StallCycles
);

  localparam bit                  MC_EN    = (MC_LAT > 1);
  localparam bit                  LU_MULTI = (LU_BUBBLES > 1);
  localparam logic [HZ_CNT_W-1:0] MC_INIT  = preload(MC_LAT);
  localparam logic [HZ_CNT_W-1:0] LU_INIT  = preload(LU_BUBBLES);
  localparam logic [REG_AW-1:0]   X0       = REG_AW'(X0_IDX);

  hz_state_e           r_state;
  hz_state_e           w_state_nxt;
  logic [HZ_CNT_W-1:0] r_cnt;
  logic [HZ_CNT_W-1:0] w_cnt_nxt;

  logic     w_rs1_hit;
  logic     w_rs2_hit;
  logic     w_lu_haz;
  logic     w_mem_wait;
  logic     w_cnt_zero;
  logic     w_mc_stall;
  logic     w_lu_stall;
  hz_ctrl_t w_ctrl;

  assign w_rs1_hit  = UseRs1_D && (RD_E == Rs1_D);
  assign w_rs2_hit  = UseRs2_D && (RD_E == Rs2_D);
  assign w_lu_haz   = MemReadE && (RD_E != X0) && (w_rs1_hit || w_rs2_hit);
  assign w_mem_wait = MemReqM && !MemReadyM;
  assign w_cnt_zero = (r_cnt == '0);

  assign w_mc_stall = ((r_state == IDLE) && MultiCycE && MC_EN) ||
                      ((r_state == MC_BUSY) && !w_cnt_zero);
  assign w_lu_stall = ((r_state == IDLE) && w_lu_haz) || (r_state == LU_STALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A multi-cycle op in E wins over a load-use hazard: E is frozen, so the
  // hazard is simply re-detected once the op leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (MultiCycE && MC_EN) begin
          w_state_nxt = MC_BUSY;
          w_cnt_nxt   = MC_INIT;
        end else if (w_lu_haz && !w_mem_wait && LU_MULTI) begin
          w_state_nxt = LU_STALL;
          w_cnt_nxt   = LU_INIT;
        end
      end
      MC_BUSY: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!w_mem_wait) begin
          w_state_nxt = IDLE;
        end
      end
      LU_STALL: begin
        if (!w_mem_wait) begin
          if (w_cnt_zero) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (w_mem_wait) begin
      w_ctrl.stall_f = 1'b1;
      w_ctrl.stall_d = 1'b1;
      w_ctrl.stall_e = 1'b1;
      w_ctrl.stall_m = 1'b1;
      w_ctrl.flush_w = 1'b1;
    end else if (w_mc_stall) begin
      w_ctrl.stall_f = 1'b1;
      w_ctrl.stall_d = 1'b1;
      w_ctrl.stall_e = 1'b1;
      w_ctrl.flush_m = 1'b1;
    end else if (w_lu_stall) begin
      w_ctrl.stall_f = 1'b1;
      w_ctrl.stall_d = 1'b1;
      w_ctrl.flush_e = 1'b1;
    end else if (PCSrcE) begin
      w_ctrl.flush_d = 1'b1;
      w_ctrl.flush_e = 1'b1;
    end
    // Reset overrides combinationally so the pipeline sees idle controls at once.
    if (rst) begin
      w_ctrl = CTRL_IDLE;
    end
  end

  assign PCWrite     = !w_ctrl.stall_f;
  assign IF_ID_Write = !w_ctrl.stall_d;
  assign StallE      = w_ctrl.stall_e;
  assign StallM      = w_ctrl.stall_m;
  assign FlushD      = w_ctrl.flush_d;
  assign FlushE      = w_ctrl.flush_e;
  assign FlushM      = w_ctrl.flush_m;
  assign FlushW      = w_ctrl.flush_w;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (!PCWrite),
    .o_count (StallCycles)
  );

endmodule
